// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (IF) and data memory (DM).
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority on contention.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Instruction fetch port (read only)
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // Data memory port
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  // Memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // Pipeline hazard control
  output logic              stall_o
);

  localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic {OwnIf, OwnDm} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic any_req;
  logic grant_dm;
  logic busy;

  assign any_req = if_req_i | dm_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_q, last_owner_d;

  // On contention the requester that was not served last wins.
  assign grant_dm = dm_req_i & (~if_req_i | (last_owner_q == OwnIf));

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == StIdle && any_req) begin
      last_owner_d = grant_dm ? OwnDm : OwnIf;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_owner_q <= OwnIf;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // DM belongs to the older instruction, so it always wins.
  assign grant_dm = dm_req_i;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = grant_dm ? OwnDm : OwnIf;
          we_d    = grant_dm & dm_we_i;
          addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          wdata_d = grant_dm ? dm_wdata_i : '0;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OwnDm) begin
              dm_rdata_d = mem_rdata_i;
            end else begin
              if_rdata_d = mem_rdata_i;
            end
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Unconditional return to idle keeps a still-high req from being re-granted here.
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 4'd0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Memory outputs are decoded from state so reset drops them without waiting for a clock.
  always_comb begin
    busy        = (state_q == StBusy);
    mem_req_o   = busy;
    mem_we_o    = busy & we_q;
    mem_addr_o  = busy ? addr_q : '0;
    mem_wdata_o = busy ? wdata_q : '0;
    if_ready_o  = (state_q == StDone) && (owner_q == OwnIf);
    dm_ready_o  = (state_q == StDone) && (owner_q == OwnDm);
    if_rdata_o  = if_rdata_q;
    dm_rdata_o  = dm_rdata_q;
    stall_o     = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized episodes
// checked against a transaction-level reference model and a behavioural memory.
module tb_mem_port_arbiter;
  localparam int L = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ready_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ready_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;

  int n_checks = 0;
  int n_fail = 0;

  // Reference state
  logic [DATA_W-1:0] shadow [64];
  logic [DATA_W-1:0] exp_if_rdata;
  logic [DATA_W-1:0] exp_dm_rdata;
  logic              last_dm;

  // Behavioural memory: data valid only in the last cycle of an access
  logic [DATA_W-1:0] mem_arr [64];
  logic              mem_load;
  int unsigned       req_run;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .MEM_LATENCY(L),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ready_o (if_ready_o),
    .if_rdata_o (if_rdata_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_ready_o (dm_ready_o),
    .dm_rdata_o (dm_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o)
  );

  function automatic logic [DATA_W-1:0] init_word(int i);
    if (i == 4) return 32'h00A0_0093;
    return {16'hC0DE, 8'(i), 8'(i * 7 + 1)};
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) req_run <= 0;
    else if (mem_req_o) req_run <= req_run + 1;
    else req_run <= 0;
  end

  always @(posedge clk_i) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
    end else if (mem_req_o && mem_we_o && req_run == L - 1) begin
      mem_arr[mem_addr_o[7:2]] <= mem_wdata_o;
    end
  end

  assign mem_rdata_i = (mem_req_o && !mem_we_o && req_run == L - 1) ?
                       mem_arr[mem_addr_o[7:2]] : {24'hBAD000, req_run[7:0]};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_load = 1'b1;
    if_req_i = 1'b1; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks += 9;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b need 0", mem_req_o); end
    if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b need 0", mem_we_o); end
    if (mem_addr_o !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr_o); end
    if (mem_wdata_o !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h need 0", mem_wdata_o); end
    if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready: got %b need 0", if_ready_o); end
    if (dm_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_dm_ready: got %b need 0", dm_ready_o); end
    if (if_rdata_o !== '0) begin n_fail++; $display("FAIL rst_if_rdata: got %h need 0", if_rdata_o); end
    if (dm_rdata_o !== '0) begin n_fail++; $display("FAIL rst_dm_rdata: got %h need 0", dm_rdata_o); end
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b need 1", stall_o); end
    tick();
    rst_i = 1'b0; mem_load = 1'b0; if_req_i = 1'b0;
    @(negedge clk_i);
    n_checks += 2;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b need 0", stall_o); end
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_mem_req: got %b need 0", mem_req_o); end
    tick();
    @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_nogrant: got %b need 0", mem_req_o); end
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    exp_if_rdata = '0; exp_dm_rdata = '0; last_dm = 1'b0;
  endtask

  task automatic test_if_read();
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    exp_if_rdata = shadow[4]; last_dm = 1'b0;
    for (int c = 0; c <= L + 1; c++) begin
      if (c > 0) tick();
      @(negedge clk_i);
      n_checks += 3;
      if (mem_req_o !== (c >= 1 && c <= L)) begin
        n_fail++; $display("FAIL ifrd_mem_req c%0d: got %b", c, mem_req_o);
      end
      if (if_ready_o !== (c == L + 1)) begin
        n_fail++; $display("FAIL ifrd_ready c%0d: got %b", c, if_ready_o);
      end
      if (stall_o !== (c <= L)) begin
        n_fail++; $display("FAIL ifrd_stall c%0d: got %b", c, stall_o);
      end
      if (c >= 1 && c <= L) begin
        n_checks += 2;
        if (mem_addr_o !== 32'h10) begin
          n_fail++; $display("FAIL ifrd_addr c%0d: got %h need 10", c, mem_addr_o);
        end
        if (mem_we_o !== 1'b0) begin
          n_fail++; $display("FAIL ifrd_we c%0d: got %b need 0", c, mem_we_o);
        end
      end
    end
    n_checks++;
    if (if_rdata_o !== 32'h00A0_0093) begin
      n_fail++; $display("FAIL ifrd_rdata: got %h need 00a00093", if_rdata_o);
    end
    tick();
    if_req_i = 1'b0;
    for (int c = L + 3; c <= 10; c++) tick();
    @(negedge clk_i);
    n_checks += 2;
    if (if_rdata_o !== exp_if_rdata) begin
      n_fail++; $display("FAIL ifrd_hold: got %h need %h", if_rdata_o, exp_if_rdata);
    end
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL ifrd_idle: got %b", mem_req_o); end
  endtask

  task automatic test_dm_write();
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c <= L + 1; c++) begin
      if (c > 0) tick();
      @(negedge clk_i);
      n_checks += 3;
      if (mem_req_o !== (c >= 1 && c <= L)) begin
        n_fail++; $display("FAIL dmwr_mem_req c%0d: got %b", c, mem_req_o);
      end
      if (dm_ready_o !== (c == L + 1)) begin
        n_fail++; $display("FAIL dmwr_ready c%0d: got %b", c, dm_ready_o);
      end
      if (if_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL dmwr_if_ready c%0d: got %b need 0", c, if_ready_o);
      end
      if (c >= 1 && c <= L) begin
        n_checks += 3;
        if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL dmwr_we c%0d: got %b", c, mem_we_o); end
        if (mem_wdata_o !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL dmwr_wdata c%0d: got %h need deadbeef", c, mem_wdata_o);
        end
        if (mem_addr_o !== 32'h20) begin
          n_fail++; $display("FAIL dmwr_addr c%0d: got %h need 20", c, mem_addr_o);
        end
      end
    end
    n_checks++;
    if (dm_rdata_o !== exp_dm_rdata) begin
      n_fail++; $display("FAIL dmwr_rdata: got %h need %h", dm_rdata_o, exp_dm_rdata);
    end
    shadow[8] = 32'hDEAD_BEEF; last_dm = 1'b1;
    tick();
    dm_req_i = 1'b0; dm_we_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int p = 0; p < 2; p++) begin
      logic dm_first;
      int   if_done, dm_done;
      logic [ADDR_W-1:0] ia, da;
      ia = 32'h24 + 32'(p * 8);
      da = 32'h20 + 32'(p * 8);
      dm_first = RR ? !last_dm : 1'b1;
      dm_done = dm_first ? L + 1 : 2 * L + 3;
      if_done = dm_first ? 2 * L + 3 : L + 1;
      exp_dm_rdata = shadow[da[7:2]];
      exp_if_rdata = shadow[ia[7:2]];
      last_dm = !dm_first;
      tick();
      if_req_i = 1'b1; if_addr_i = ia;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = da;
      for (int c = 0; c <= 2 * L + 3; c++) begin
        logic b_if, b_dm;
        if (c > 0) begin
          tick();
          if (c == if_done + 1) if_req_i = 1'b0;
          if (c == dm_done + 1) dm_req_i = 1'b0;
        end
        @(negedge clk_i);
        b_if = (c >= if_done - L) && (c < if_done);
        b_dm = (c >= dm_done - L) && (c < dm_done);
        n_checks += 4;
        if (mem_req_o !== (b_if | b_dm)) begin
          n_fail++; $display("FAIL sim%0d_mem_req c%0d: got %b", p, c, mem_req_o);
        end
        if (if_ready_o !== (c == if_done)) begin
          n_fail++; $display("FAIL sim%0d_if_ready c%0d: got %b", p, c, if_ready_o);
        end
        if (dm_ready_o !== (c == dm_done)) begin
          n_fail++; $display("FAIL sim%0d_dm_ready c%0d: got %b", p, c, dm_ready_o);
        end
        if (stall_o !== (c < if_done || c < dm_done)) begin
          n_fail++; $display("FAIL sim%0d_stall c%0d: got %b", p, c, stall_o);
        end
        if (b_if || b_dm) begin
          n_checks++;
          if (mem_addr_o !== (b_dm ? da : ia)) begin
            n_fail++; $display("FAIL sim%0d_addr c%0d: got %h", p, c, mem_addr_o);
          end
        end
      end
      n_checks += 2;
      if (if_rdata_o !== exp_if_rdata) begin
        n_fail++; $display("FAIL sim%0d_if_rdata: got %h need %h", p, if_rdata_o, exp_if_rdata);
      end
      if (dm_rdata_o !== exp_dm_rdata) begin
        n_fail++; $display("FAIL sim%0d_dm_rdata: got %h need %h", p, dm_rdata_o, exp_dm_rdata);
      end
    end
    tick();
    if_req_i = 1'b0; dm_req_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h28;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    n_checks += 3;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_req: got %b need 0", mem_req_o); end
    if (dm_rdata_o !== '0) begin n_fail++; $display("FAIL rmid_dm_rdata: got %h need 0", dm_rdata_o); end
    if (if_rdata_o !== '0) begin n_fail++; $display("FAIL rmid_if_rdata: got %h need 0", if_rdata_o); end
    tick();
    @(negedge clk_i);
    n_checks++;
    if (dm_ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_dm_ready: got %b need 0", dm_ready_o); end
    exp_if_rdata = '0; exp_dm_rdata = shadow[10]; last_dm = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int c = 0; c <= L + 1; c++) begin
      if (c > 0) tick();
      @(negedge clk_i);
      n_checks += 2;
      if (dm_ready_o !== (c == L + 1)) begin
        n_fail++; $display("FAIL rmid_restart_ready c%0d: got %b", c, dm_ready_o);
      end
      if (mem_req_o !== (c >= 1 && c <= L)) begin
        n_fail++; $display("FAIL rmid_restart_req c%0d: got %b", c, mem_req_o);
      end
    end
    n_checks++;
    if (dm_rdata_o !== exp_dm_rdata) begin
      n_fail++; $display("FAIL rmid_rdata: got %h need %h", dm_rdata_o, exp_dm_rdata);
    end
    tick();
    dm_req_i = 1'b0;
  endtask

  task automatic test_req_drop();
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h2C;
    exp_if_rdata = shadow[11]; last_dm = 1'b0;
    tick();
    if_req_i = 1'b0;
    for (int c = 2; c <= L + 5; c++) begin
      tick();
      @(negedge clk_i);
      n_checks += 2;
      if (if_ready_o !== (c == L + 1)) begin
        n_fail++; $display("FAIL drop_ready c%0d: got %b", c, if_ready_o);
      end
      if (mem_req_o !== (c <= L)) begin
        n_fail++; $display("FAIL drop_mem_req c%0d: got %b", c, mem_req_o);
      end
    end
    n_checks++;
    if (if_rdata_o !== exp_if_rdata) begin
      n_fail++; $display("FAIL drop_rdata: got %h need %h", if_rdata_o, exp_if_rdata);
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 40; ep++) begin
      int   kind, gap, if_grant, dm_grant, if_done, dm_done, last;
      logic use_if, use_dm, dm_we, dm_first;
      logic [ADDR_W-1:0] ia, da;
      logic [DATA_W-1:0] wd;
      kind = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      ia = $urandom; ia[7:0] = 8'($urandom_range(0, 7) * 4);
      da = $urandom; da[7:0] = 8'($urandom_range(0, 7) * 4);
      dm_we = 1'($urandom_range(0, 1));
      wd = $urandom;
      use_if = (kind != 1);
      use_dm = (kind != 0);
      dm_first = RR ? !last_dm : 1'b1;
      if_grant = -100; dm_grant = -100;
      if (use_if && use_dm) begin
        dm_grant = dm_first ? 0 : L + 2;
        if_grant = dm_first ? L + 2 : 0;
      end else if (use_if) begin
        if_grant = 0;
      end else begin
        dm_grant = 0;
      end
      // Apply accesses to the reference memory in service order
      for (int k = 0; k < 2; k++) begin
        if (use_dm && dm_grant == k * (L + 2)) begin
          if (dm_we) shadow[da[7:2]] = wd;
          else exp_dm_rdata = shadow[da[7:2]];
          last_dm = 1'b1;
        end
        if (use_if && if_grant == k * (L + 2)) begin
          exp_if_rdata = shadow[ia[7:2]];
          last_dm = 1'b0;
        end
      end
      if_done = use_if ? if_grant + L + 1 : -100;
      dm_done = use_dm ? dm_grant + L + 1 : -100;
      last = (if_done > dm_done) ? if_done : dm_done;
      repeat (gap) begin
        tick();
        if_req_i = 1'b0; dm_req_i = 1'b0;
      end
      tick();
      if_req_i = use_if; if_addr_i = ia;
      dm_req_i = use_dm; dm_we_i = dm_we; dm_addr_i = da; dm_wdata_i = wd;
      for (int c = 0; c <= last; c++) begin
        logic b_if, b_dm;
        if (c > 0) begin
          tick();
          if (c == if_done + 1) if_req_i = 1'b0;
          if (c == dm_done + 1) dm_req_i = 1'b0;
        end
        @(negedge clk_i);
        b_if = use_if && (c > if_grant) && (c <= if_grant + L);
        b_dm = use_dm && (c > dm_grant) && (c <= dm_grant + L);
        n_checks += 4;
        if (mem_req_o !== (b_if | b_dm)) begin
          n_fail++; $display("FAIL rnd%0d_mem_req c%0d: got %b", ep, c, mem_req_o);
        end
        if (if_ready_o !== (c == if_done)) begin
          n_fail++; $display("FAIL rnd%0d_if_ready c%0d: got %b", ep, c, if_ready_o);
        end
        if (dm_ready_o !== (c == dm_done)) begin
          n_fail++; $display("FAIL rnd%0d_dm_ready c%0d: got %b", ep, c, dm_ready_o);
        end
        if (stall_o !== (c < if_done || c < dm_done)) begin
          n_fail++; $display("FAIL rnd%0d_stall c%0d: got %b", ep, c, stall_o);
        end
        if (b_if || b_dm) begin
          n_checks += 2;
          if (mem_addr_o !== (b_dm ? da : ia)) begin
            n_fail++; $display("FAIL rnd%0d_addr c%0d: got %h", ep, c, mem_addr_o);
          end
          if (mem_we_o !== (b_dm & dm_we)) begin
            n_fail++; $display("FAIL rnd%0d_we c%0d: got %b", ep, c, mem_we_o);
          end
          if (b_dm && dm_we) begin
            n_checks++;
            if (mem_wdata_o !== wd) begin
              n_fail++; $display("FAIL rnd%0d_wdata c%0d: got %h need %h", ep, c, mem_wdata_o, wd);
            end
          end
        end
        if (c == if_done) begin
          n_checks++;
          if (if_rdata_o !== exp_if_rdata) begin
            n_fail++; $display("FAIL rnd%0d_if_rdata: got %h need %h", ep, if_rdata_o, exp_if_rdata);
          end
        end
        if (c == dm_done) begin
          n_checks++;
          if (dm_rdata_o !== exp_dm_rdata) begin
            n_fail++; $display("FAIL rnd%0d_dm_rdata: got %h need %h", ep, dm_rdata_o, exp_dm_rdata);
          end
        end
      end
    end
    tick();
    if_req_i = 1'b0; dm_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write();
    test_simultaneous();
    test_reset_mid();
    test_req_drop();
    test_random();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
